// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    // Fetch controller state encoding
    typedef logic [1:0] state_t;

    localparam state_t S_REQ  = 2'd0;   // free to issue a request
    localparam state_t S_WAIT = 2'd1;   // request outstanding, response wanted
    localparam state_t S_DROP = 2'd2;   // request outstanding, response stale

    // Byte distance between consecutive instruction words
    localparam logic [31:0] PC_STEP    = 32'd4;

    // Value shown on the decode interface when nothing is buffered
    localparam logic [31:0] EMPTY_WORD = 32'h0;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small power-of-two FIFO holding {pc, instr} pairs between the
//                instruction memory and decode. Flush overrides push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [63:0]   din,
    output logic [AW:0]   count,
    output logic [63:0]   head
);
    import fetch_pkg::*;

    localparam logic [AW-1:0] c_ptr_one = AW'(1);
    localparam logic [AW:0]   c_cnt_one = (AW + 1)'(1);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;

    // Storage write; a flushed push is discarded along with everything else
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wr <= r_wr + c_ptr_one;
            end
            if (pop) begin
                r_rd <= r_rd + c_ptr_one;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = (r_count == '0) ? {EMPTY_WORD, EMPTY_WORD} : r_mem[r_rd];

endmodule : fetch_fifo

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch stage. Owns the PC, issues one request at a
//                time to a variable-latency instruction memory, buffers the
//                returned words and hands them to decode over valid/ready.
//                Redirects flush buffered and in-flight words.
//                Optional macro HALT_DETECT_EN: stop fetching once HALT_INSTR
//                has been buffered (adds the halted output).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
`ifdef HALT_DETECT_EN
    ,
    parameter logic [31:0] HALT_INSTR = 32'hac020054
`endif
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
`ifdef HALT_DETECT_EN
    ,
    output logic        halted
`endif
);
    import fetch_pkg::*;

    localparam int            c_aw    = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(FIFO_DEPTH);

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic [c_aw:0] w_count;
    logic [63:0]   w_head;
    logic          w_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_halted;

    // A request is only offered when its response is guaranteed a FIFO slot
    assign imem_req    = !reset && (r_state == S_REQ) && (w_count < c_depth)
                         && !w_halted && !redirect_valid;
    assign imem_addr   = r_pc;
    assign w_fire      = imem_req && imem_ready;

    // A response arriving alongside a redirect is stale and never buffered
    assign w_push      = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;

    assign instr_valid = (w_count != '0);
    assign w_pop       = instr_valid && instr_ready;
    assign instruction = w_head[31:0];
    assign instr_pc    = w_head[63:32];

`ifdef HALT_DETECT_EN
    logic r_halted;

    // Sticky halt flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (w_push && (imem_rdata == HALT_INSTR)) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
    assign halted   = r_halted;
`else
    assign w_halted = 1'b0;
`endif

    // Request/response sequencing with redirect taking priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
            // A request still in flight must be swallowed before a new one
            // may go out, otherwise two requests would be outstanding.
            if (((r_state == S_WAIT) || (r_state == S_DROP)) && !imem_rvalid) begin
                r_state <= S_DROP;
            end else begin
                r_state <= S_REQ;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_fire) begin
                        r_pc     <= r_pc + PC_STEP;
                        r_req_pc <= r_pc;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_valid),
        .din   ({r_req_pc, imem_rdata}),
        .count (w_count),
        .head  (w_head)
    );

endmodule : instr_fetch

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. A memory model with
//                random latency answers requests; a queue-based reference
//                model predicts every decode-side and request-side output.
//                Macro HALT_DETECT_EN enables the halt checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam int          DEPTH     = 2;
    localparam logic [31:0] HALT_WORD = 32'hac020054;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
`ifdef HALT_DETECT_EN
    logic        halted;
`endif

    instr_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_ready     (imem_ready),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
`ifdef HALT_DETECT_EN
        ,
        .halted         (halted)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: buffered {pc, word} pairs, next fetch address,
    // one in-flight memory request and whether its answer is still wanted.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic        m_out;
    logic        m_drop;
    logic        m_halted;
    int          m_cnt;
    logic [31:0] halt_addr = 32'hFFFF_FFFF;

    // Stimulus knobs
    int          v_lat;
    logic        v_imem_ready;
    logic        v_instr_ready;
    logic        v_redirect;
    logic [31:0] v_redirect_pc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == halt_addr) return HALT_WORD;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    // One clock: drive inputs at the falling edge, check, then advance model
    task automatic cycle();
        logic        rv;
        logic        exp_req;
        logic        fire;
        logic [31:0] rd;
        logic [63:0] hd;
        @(negedge clk);
        rv = 1'b0;
        if (m_out) begin
            m_cnt--;
            rv = (m_cnt == 0);
        end
        rd             = rv ? memword(m_addr) : $urandom();
        imem_rvalid    = rv;
        imem_rdata     = rd;
        imem_ready     = v_imem_ready;
        instr_ready    = v_instr_ready;
        redirect_valid = v_redirect;
        redirect_pc    = v_redirect_pc;
        #1;
        exp_req = !m_halted && (exp_q.size() < DEPTH) && !m_out && !v_redirect;
        hd      = (exp_q.size() > 0) ? exp_q[0] : 64'h0;
        chk("imem_req",    {63'h0, imem_req},    {63'h0, exp_req});
        chk("imem_addr",   {32'h0, imem_addr},   {32'h0, m_pc});
        chk("instr_valid", {63'h0, instr_valid}, {63'h0, (exp_q.size() > 0)});
        chk("instruction", {32'h0, instruction}, {32'h0, hd[31:0]});
        chk("instr_pc",    {32'h0, instr_pc},    {32'h0, hd[63:32]});
`ifdef HALT_DETECT_EN
        chk("halted",      {63'h0, halted},      {63'h0, m_halted});
`endif
        fire = exp_req && v_imem_ready;
        if (v_redirect) begin
            exp_q.delete();
            m_pc = v_redirect_pc;
            if (rv) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
        end else begin
            if ((exp_q.size() > 0) && v_instr_ready) void'(exp_q.pop_front());
            if (rv) begin
                if (!m_drop) begin
                    exp_q.push_back({m_addr, rd});
`ifdef HALT_DETECT_EN
                    if (rd == HALT_WORD) m_halted = 1'b1;
`endif
                end
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            if (fire) begin
                m_out  = 1'b1;
                m_addr = m_pc;
                m_cnt  = (v_lat == 0) ? int'($urandom_range(1, 3)) : v_lat;
                m_pc   = m_pc + 32'd4;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        v_redirect    = 1'b1;
        v_redirect_pc = pc;
        cycle();
        v_redirect    = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        imem_ready     = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        v_redirect     = 1'b0;
        v_redirect_pc  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_imem_req",    {63'h0, imem_req},    64'h0);
        chk("rst_imem_addr",   {32'h0, imem_addr},   64'h0);
        chk("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
        chk("rst_instruction", {32'h0, instruction}, 64'h0);
        chk("rst_instr_pc",    {32'h0, instr_pc},    64'h0);
`ifdef HALT_DETECT_EN
        chk("rst_halted",      {63'h0, halted},      64'h0);
`endif
        exp_q.delete();
        m_pc     = 32'h0;
        m_addr   = 32'h0;
        m_out    = 1'b0;
        m_drop   = 1'b0;
        m_halted = 1'b0;
        m_cnt    = 0;
        // Leave imem_ready low across the release edge so nothing is accepted
        reset    = 1'b0;
    endtask

    initial begin
        int first;

        // Straight-line fetch, 1-cycle memory, decode always ready
        do_reset();
        v_lat = 1; v_imem_ready = 1'b1; v_instr_ready = 1'b1;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if ((first == 0) && instr_valid) first = i;
        end
        chk("first_valid_cycle", 64'(first), 64'd3);

        // Backpressure: buffer fills, requests stop, then drain in order
        do_reset();
        v_lat = 1; v_imem_ready = 1'b1; v_instr_ready = 1'b0;
        run(8);
        chk("bp_req_held", {63'h0, imem_req}, 64'h0);
        chk("bp_addr_next", {32'h0, imem_addr}, 64'h8);
        v_instr_ready = 1'b1;
        run(8);

        // Redirect while the 0x4 request is outstanding
        do_reset();
        v_lat = 3; v_imem_ready = 1'b1; v_instr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (m_out && (m_addr == 32'h4)) break;
        end
        redirect_to(32'h40);
        run(12);

        // Redirect coinciding with the response
        v_lat = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (m_out) break;
        end
        redirect_to(32'h80);
        run(8);

        // PC wrap
        v_lat = 0;
        redirect_to(32'hFFFF_FFFC);
        run(10);

        // Randomised traffic with redirects and random latency
        for (int i = 0; i < 3000; i++) begin
            v_imem_ready  = ($urandom_range(0, 3) != 0);
            v_instr_ready = ($urandom_range(0, 3) != 0);
            v_redirect    = ($urandom_range(0, 15) == 0);
            v_redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                                        : ($urandom() & 32'hFFFF_FFFC);
            cycle();
        end
        v_redirect = 1'b0;

        // Reset in the middle of traffic
        v_imem_ready = 1'b1; v_instr_ready = 1'b0;
        run(3);
        do_reset();
        v_instr_ready = 1'b1;
        run(20);

`ifdef HALT_DETECT_EN
        // Halt word at 0x10 stops fetch; redirects do not clear it
        do_reset();
        halt_addr = 32'h10;
        v_lat = 1; v_imem_ready = 1'b1; v_instr_ready = 1'b1;
        run(20);
        chk("halt_set",   {63'h0, halted},   64'h1);
        chk("halt_noreq", {63'h0, imem_req}, 64'h0);
        redirect_to(32'h100);
        run(6);
        chk("halt_kept",  {63'h0, halted},   64'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_instr_fetch

`default_nettype wire
